// File: rtl/counter_seq_if.sv
// Command push channel into counter_seq: valid/ready handshake carrying opcode and argument.
interface counter_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/counter_seq.sv
// Command FIFO plus FSM driving an 8-bit preloadable counter; outputs move 2 cycles after a push into an idle block.
// Backpressure: cmd_ready is low while the FIFO is full or reset is asserted.
module counter_seq #(
    parameter int FIFO_DEPTH  = 4,
    parameter int WAIT_TO     = 1023,
    parameter bit IDLE_ENABLE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    counter_seq_if.slave cmd,
    input  logic         clr_err,
    input  logic [7:0]   cout,
    output logic         enable,
    output logic         preload,
    output logic [3:0]   pl_data,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] TO_LAST  = 16'(WAIT_TO - 1);

    localparam logic [1:0] OP_RUN  = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_HOLD = 2'd2;
    localparam logic [1:0] OP_WAIT = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_LOAD, S_HOLD, S_WAIT} state_t;

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          w_full, w_empty, w_push, w_pop;
    logic [1:0]    w_head_op;
    logic [7:0]    w_head_arg;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_cnt, w_cnt_nxt;
    logic [7:0]    r_tgt, w_tgt_nxt;
    logic [15:0]   r_wcnt, w_wcnt_nxt;
    logic          r_enable, r_preload, r_done, r_err;
    logic [3:0]    r_pl_data;
    logic          w_enable_nxt, w_preload_nxt, w_err_nxt;
    logic [3:0]    w_pl_data_nxt;
    logic          w_match, w_timeout, w_last;

    assign w_full        = (r_count == FULL_CNT);
    assign w_empty       = (r_count == '0);
    assign cmd.cmd_ready = !w_full && !reset;
    assign w_push        = cmd.cmd_valid && cmd.cmd_ready;
    assign {w_head_op, w_head_arg} = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {cmd.cmd_op, cmd.cmd_arg};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Match beats timeout when both land on the same cycle.
    assign w_match   = (cout == r_tgt);
    assign w_timeout = (r_wcnt == TO_LAST);

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_RUN, S_HOLD: w_last = (r_cnt == 8'd0);
            S_LOAD:        w_last = 1'b1;
            S_WAIT:        w_last = w_match || w_timeout;
            default:       w_last = 1'b0;
        endcase
    end

    assign w_pop = !w_empty && ((r_state == S_IDLE) || w_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tgt     <= '0;
            r_wcnt    <= '0;
            r_enable  <= 1'b0;
            r_preload <= 1'b0;
            r_pl_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tgt     <= w_tgt_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_enable  <= w_enable_nxt;
            r_preload <= w_preload_nxt;
            r_pl_data <= w_pl_data_nxt;
            r_done    <= w_last;
            r_err     <= w_err_nxt;
        end
    end

    // Count register holds remaining cycles minus one, so arg 0 wraps to 256 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tgt_nxt   = r_tgt;
        w_wcnt_nxt  = r_wcnt;
        w_err_nxt   = r_err;
        if (clr_err) w_err_nxt = 1'b0;
        if ((r_state == S_WAIT) && w_timeout && !w_match) w_err_nxt = 1'b1;
        if (w_pop) begin
            case (w_head_op)
                OP_RUN:  w_state_nxt = S_RUN;
                OP_LOAD: w_state_nxt = S_LOAD;
                OP_HOLD: w_state_nxt = S_HOLD;
                default: w_state_nxt = S_WAIT;
            endcase
            w_cnt_nxt  = w_head_arg - 8'd1;
            w_tgt_nxt  = w_head_arg;
            w_wcnt_nxt = '0;
        end else if (w_last) begin
            w_state_nxt = S_IDLE;
        end else begin
            if ((r_state == S_RUN) || (r_state == S_HOLD)) w_cnt_nxt = r_cnt - 8'd1;
            if (r_state == S_WAIT) w_wcnt_nxt = r_wcnt + 16'd1;
        end
    end

    always_comb begin
        w_enable_nxt  = 1'b0;
        w_preload_nxt = 1'b0;
        w_pl_data_nxt = r_pl_data;
        case (w_state_nxt)
            S_IDLE: w_enable_nxt = IDLE_ENABLE;
            S_RUN:  w_enable_nxt = 1'b1;
            S_LOAD: begin
                w_enable_nxt  = 1'b1;
                w_preload_nxt = 1'b1;
                w_pl_data_nxt = w_tgt_nxt[3:0];
            end
            default: w_enable_nxt = 1'b0;
        endcase
    end

    // In WAIT the counter must stop on the very cycle cout reaches the target.
    assign enable  = (r_state == S_WAIT) ? (cout != r_tgt) : r_enable;
    assign preload = r_preload;
    assign pl_data = r_pl_data;
    assign done    = r_done;
    assign err     = r_err;
    assign busy    = (r_state != S_IDLE) || !w_empty;
endmodule

// File: doc/counter_seq.md
Name: counter_seq

Overview:
- Command-driven sequencer for the team's 8-bit preloadable counter. It drives the counter's enable, preload and pl_data inputs, and it monitors the counter's cout.
- A host pushes commands into a small FIFO through a valid/ready handshake. The FSM executes them back-to-back: run N cycles, preload a value, hold N cycles, or run until cout reaches a target.
- This block replaces hand-sequenced preload/stop stimulus with a reusable controller.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- WAIT_TO, 1023, maximum cycles a WAIT command may run before timeout; 1 to 65535.
- IDLE_ENABLE, 1, value driven on enable while idle with the FIFO empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host presents a command.
- cmd_ready  out  1  FIFO can accept a command; equals !fifo_full.
- cmd_op  in  2  opcode: 0=RUN, 1=LOAD, 2=HOLD, 3=WAIT.
- cmd_arg  in  8  cycle count (RUN/HOLD), preload data in [3:0] (LOAD), or cout target (WAIT).
- clr_err  in  1  clears err (synchronous).
- cout  in  8  counter value, fed back from the counter.
- enable  out  1  to counter enable.
- preload  out  1  to counter preload.
- pl_data  out  4  to counter pl_data.
- busy  out  1  high when state != IDLE or the FIFO is non-empty.
- done  out  1  one-cycle pulse on each command retirement.
- err  out  1  sticky WAIT-timeout flag.

Behaviour:
- Reset values: enable=0, preload=0, pl_data=0, done=0, err=0, busy=0, cmd_ready=0.
- While reset is asserted, the FIFO is flushed and the FSM is forced to IDLE.
- In the first cycle after reset deasserts: cmd_ready=1 and enable=IDLE_ENABLE.
- Reset mid-command aborts the command immediately. No done pulse is generated and queued commands are lost.
- Push rule: a command is accepted on any edge where cmd_valid && cmd_ready.
- Pop rule: the FSM pops when in IDLE with the FIFO non-empty, or on the final cycle of the current command with the FIFO non-empty.
- Simultaneous push and pop on a full FIFO is not permitted, because cmd_ready is low when full.
- A command pushed into an empty FIFO while IDLE takes effect on outputs 2 cycles after acceptance: 1 cycle in the FIFO, 1 cycle for pop/decode.
- FSM states: IDLE, RUN, LOAD, HOLD, WAIT.
  - IDLE: enable=IDLE_ENABLE, preload=0. Pop leads to the state given by cmd_op.
  - RUN: enable=1 for exactly cmd_arg cycles. cmd_arg=0 means 256 cycles.
  - LOAD: exactly 1 cycle with preload=1, enable=1, pl_data=cmd_arg[3:0]. pl_data holds its last value after LOAD.
  - HOLD: enable=0, preload=0 for exactly cmd_arg cycles. cmd_arg=0 means 256 cycles.
  - WAIT: enable = (cout != cmd_arg), driven combinationally from the registered target and the cout input, so the counter stops on the target. The command retires in the first cycle where cout == target. If cout already equals the target on entry, WAIT lasts 1 cycle with enable=0.
- WAIT timeout: a 16-bit cycle counter runs in WAIT. If WAIT_TO cycles elapse without a match, the command retires and err is set. err stays set until clr_err or reset. Timeout and match on the same cycle count as a match.
- Retirement:
  - done=1 in the cycle after a command's last active cycle.
  - The next queued command's first active cycle coincides with that done cycle, so there are no bubbles between queued commands.
  - With the FIFO empty, the FSM returns to IDLE in the cycle the done pulse is issued.
- clr_err and a timeout on the same cycle: err ends set.
- enable, preload and pl_data are registered, except enable in WAIT.
- Counter semantics (external, but relied on here): preload wins over enable; cout wraps 255 to 0.

Test Plan:
- Reset, then push RUN 26 with cout initially 0 → enable=1 for exactly 26 cycles, cout=26, one done pulse, then enable=IDLE_ENABLE and busy=0.
- Push LOAD 5, RUN 10, LOAD 2, RUN 10, HOLD 10 back-to-back → no gap cycles between commands. cout sequence: 5, then 15, then 2, then 12, held at 12 for 10 cycles. Exactly 5 done pulses.
- Fill the FIFO with cmd_valid held high while a RUN 200 executes → cmd_ready drops after 4 accepts. It rises the cycle after the next pop. No command is lost or duplicated.
- LOAD 0, then WAIT 0x80 → enable deasserts when cout=0x80, the counter holds at 0x80, done pulses, err=0.
- Set WAIT_TO=20, then HOLD 5 at cout=0, then WAIT 0xFF → timeout after 20 cycles with err=1. Pulse clr_err → err=0.
- Assert reset midway through RUN 100 with 2 commands queued → all outputs return to reset values asynchronously, with no done pulse. After release, busy=0 and cmd_ready=1.
